// File: rtl/lte_sym_framer.sv
// rtl/lte_sym_framer.sv - LTE symbol-timing scheduler producing CP/body framing strobes for preproc
module lte_sym_framer #(
    parameter int DATA_NBIT = 15,
    parameter int SLOT_NUM  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           cfg_fft_num,
    input  logic                 cfg_cp_type,
    input  logic                 sync_in,
    input  logic [DATA_NBIT-1:0] src_i,
    input  logic [DATA_NBIT-1:0] src_q,
    input  logic                 src_v,
    output logic [DATA_NBIT-1:0] dout_i,
    output logic [DATA_NBIT-1:0] dout_q,
    output logic                 dout_v,
    output logic                 dout_h,
    output logic                 dout_s,
    output logic [2:0]           dout_sym,
    output logic [4:0]           dout_slot,
    output logic                 sync_lost,
    output logic                 cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;

    localparam logic [4:0] LP_SLOT_LAST = 5'(SLOT_NUM - 1);

    state_t               r_state;
    logic [11:0]          r_cnt;
    logic [2:0]           r_sym;
    logic [4:0]           r_slot;
    logic [2:0]           r_n;
    logic                 r_ext;
    logic                 r_cfg_err;
    logic [DATA_NBIT-1:0] r_dout_i;
    logic [DATA_NBIT-1:0] r_dout_q;
    logic                 r_dout_v;
    logic                 r_dout_h;
    logic                 r_dout_s;
    logic [2:0]           r_dout_sym;
    logic [4:0]           r_dout_slot;
    logic                 r_sync_lost;

    state_t               w_state_nxt;
    logic [11:0]          w_cnt_nxt;
    logic [2:0]           w_sym_nxt;
    logic [4:0]           w_slot_nxt;

    // A sync sample is processed as if the frame position were already slot0/sym0/CP0.
    logic                 w_restart;
    logic                 w_active;
    logic                 w_expected;
    state_t               w_pos_state;
    logic [11:0]          w_pos_cnt;
    logic [2:0]           w_pos_sym;
    logic [4:0]           w_pos_slot;
    logic                 w_latch;
    logic                 w_cfg_ok;
    logic [2:0]           w_n;
    logic                 w_ext;
    logic [11:0]          w_fft_len;
    logic [11:0]          w_cp_len;
    logic [2:0]           w_last_sym;
    logic                 w_head;

    assign w_restart   = src_v & sync_in;
    assign w_active    = src_v & (sync_in | (r_state != S_IDLE));
    assign w_expected  = (r_state == S_CP) && (r_cnt == 12'd0) && (r_sym == 3'd0) && (r_slot == 5'd0);
    assign w_pos_state = w_restart ? S_CP  : r_state;
    assign w_pos_cnt   = w_restart ? 12'd0 : r_cnt;
    assign w_pos_sym   = w_restart ? 3'd0  : r_sym;
    assign w_pos_slot  = w_restart ? 5'd0  : r_slot;

    // Config is only taken at the head of symbol 0 so a slot never mixes two timings.
    assign w_latch    = w_active && (w_pos_state == S_CP) && (w_pos_cnt == 12'd0) && (w_pos_sym == 3'd0);
    assign w_cfg_ok   = (cfg_fft_num <= 3'd4);
    assign w_n        = (w_latch && w_cfg_ok) ? cfg_fft_num : r_n;
    assign w_ext      = (w_latch && w_cfg_ok) ? cfg_cp_type : r_ext;
    assign w_fft_len  = 12'd2048 >> w_n;
    assign w_cp_len   = w_ext ? (12'd512 >> w_n) :
                        ((w_pos_sym == 3'd0) ? (12'd160 >> w_n) : (12'd144 >> w_n));
    assign w_last_sym = w_ext ? 3'd5 : 3'd6;
    assign w_head     = w_active && (w_pos_state == S_CP) && (w_pos_cnt == 12'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sym_nxt   = r_sym;
        w_slot_nxt  = r_slot;
        if (w_active) begin
            w_state_nxt = w_pos_state;
            w_sym_nxt   = w_pos_sym;
            w_slot_nxt  = w_pos_slot;
            w_cnt_nxt   = w_pos_cnt + 12'd1;
            case (w_pos_state)
                S_CP: begin
                    if (w_pos_cnt == w_cp_len - 12'd1) begin
                        w_state_nxt = S_BODY;
                        w_cnt_nxt   = 12'd0;
                    end
                end
                S_BODY: begin
                    if (w_pos_cnt == w_fft_len - 12'd1) begin
                        w_state_nxt = S_CP;
                        w_cnt_nxt   = 12'd0;
                        if (w_pos_sym == w_last_sym) begin
                            w_sym_nxt  = 3'd0;
                            w_slot_nxt = (w_pos_slot == LP_SLOT_LAST) ? 5'd0 : w_pos_slot + 5'd1;
                        end else begin
                            w_sym_nxt = w_pos_sym + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 12'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 12'd0;
            r_sym       <= 3'd0;
            r_slot      <= 5'd0;
            r_n         <= 3'd0;
            r_ext       <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_dout_i    <= '0;
            r_dout_q    <= '0;
            r_dout_v    <= 1'b0;
            r_dout_h    <= 1'b0;
            r_dout_s    <= 1'b0;
            r_dout_sym  <= 3'd0;
            r_dout_slot <= 5'd0;
            r_sync_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sym       <= w_sym_nxt;
            r_slot      <= w_slot_nxt;
            r_n         <= w_n;
            r_ext       <= w_ext;
            if (w_latch && !w_cfg_ok) begin
                r_cfg_err <= 1'b1;
            end
            r_dout_i    <= src_i;
            r_dout_q    <= src_q;
            r_dout_v    <= w_active;
            r_dout_h    <= w_head;
            r_dout_s    <= w_head && (w_pos_sym == 3'd0);
            if (w_active) begin
                r_dout_sym  <= w_pos_sym;
                r_dout_slot <= w_pos_slot;
            end
            r_sync_lost <= w_restart && (r_state != S_IDLE) && !w_expected;
        end
    end

    assign dout_i    = r_dout_i;
    assign dout_q    = r_dout_q;
    assign dout_v    = r_dout_v;
    assign dout_h    = r_dout_h;
    assign dout_s    = r_dout_s;
    assign dout_sym  = r_dout_sym;
    assign dout_slot = r_dout_slot;
    assign sync_lost = r_sync_lost;
    assign cfg_err   = r_cfg_err;

endmodule
